// File: rtl/uart_autobaud.sv
// uart_autobaud: measures the bit period of a 0x55 sync character on the raw
// RX line and publishes clocks-per-bit (CPB) with LOCKED until RELOCK.
// Optional build macro UART_AUTOBAUD_CHECK_EN adds a per-interval consistency
// check that rejects characters whose edge spacing is not uniform.
module uart_autobaud #(
  parameter int CPB_WIDTH   = 12,
  parameter int MIN_CPB     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 RX_PIN,
  input  logic                 RELOCK,
  output logic [CPB_WIDTH-1:0] CPB,
  output logic                 LOCKED,
  output logic                 ERR
);

  localparam int CNT_W = CPB_WIDTH + 3;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W:0]     ROUND     = (CNT_W+1)'(4);
  localparam logic [CPB_WIDTH:0] MIN_CPB_V = (CPB_WIDTH+1)'(MIN_CPB);
  localparam logic [4:0]         IDLE_LAST = 5'd15;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_START = 3'd1;
  localparam logic [2:0] S_MEASURE    = 3'd2;
  localparam logic [2:0] S_WAIT_STOP  = 3'd3;
  localparam logic [2:0] S_LOCK       = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev;
  logic [2:0]             r_state;
  logic [4:0]             r_idle_cnt;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_edge_cnt;
  logic [CPB_WIDTH-1:0]   r_cpb_next;
  logic [CPB_WIDTH-1:0]   r_cpb;
  logic                   r_locked;
  logic                   r_err;

  logic                   w_rx_s;
  logic                   w_fall;
  logic                   w_rise;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic [CPB_WIDTH:0]     w_cpb_next;
  logic                   w_cpb_bad;

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_rx_prev & ~w_rx_s;
  assign w_rise    = ~r_rx_prev & w_rx_s;
  // Cycles elapsed since the start edge, including the current one.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cpb_next = (CPB_WIDTH+1)'(({1'b0, w_cnt_inc} + ROUND) >> 3);
  assign w_cpb_bad  = w_cpb_next[CPB_WIDTH] | (w_cpb_next < MIN_CPB_V);

`ifdef UART_AUTOBAUD_CHECK_EN
  logic [CNT_W-1:0] r_ival;
  logic [CNT_W-1:0] r_ref;
  logic             r_have_ref;
  logic             w_any_edge;
  logic [CNT_W-1:0] w_ival_inc;
  logic [CNT_W-1:0] w_ival_diff;
  logic             w_ival_bad;

  assign w_any_edge  = w_fall | w_rise;
  assign w_ival_inc  = r_ival + 1'b1;
  assign w_ival_diff = (w_ival_inc >= r_ref) ? (w_ival_inc - r_ref) : (r_ref - w_ival_inc);
  assign w_ival_bad  = r_have_ref & (w_ival_diff > (r_ref >> 2));
`endif

  // Synchronize the raw line and keep its previous value for edge detection.
  // NOTE: the chain resets to the idle-high level so reset release never
  // fabricates a falling edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_sync    <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], RX_PIN};
      r_rx_prev <= w_rx_s;
    end
  end

  // Detection FSM: idle qualification, period measurement, lock and reject.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= '0;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_cpb_next <= '0;
      r_cpb      <= '0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
`ifdef UART_AUTOBAUD_CHECK_EN
      r_ival     <= '0;
      r_ref      <= '0;
      r_have_ref <= 1'b0;
`endif
    end else begin
      // NOTE: default-low each cycle makes ERR a single-cycle pulse.
      r_err <= 1'b0;
      if (RELOCK && (r_state != S_IDLE)) begin
        r_state    <= S_IDLE;
        r_idle_cnt <= '0;
        r_locked   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rx_s) begin
              if (r_idle_cnt == IDLE_LAST) begin
                r_idle_cnt <= '0;
                r_state    <= S_WAIT_START;
              end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
              end
            end else begin
              r_idle_cnt <= '0;
            end
          end
          S_WAIT_START: begin
            if (w_fall) begin
              r_cnt      <= '0;
              r_edge_cnt <= '0;
`ifdef UART_AUTOBAUD_CHECK_EN
              r_ival     <= '0;
              r_ref      <= '0;
              r_have_ref <= 1'b0;
`endif
              r_state    <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            r_cnt <= w_cnt_inc;
`ifdef UART_AUTOBAUD_CHECK_EN
            r_ival <= w_any_edge ? '0 : w_ival_inc;
            if (w_any_edge && !r_have_ref) begin
              r_ref      <= w_ival_inc;
              r_have_ref <= 1'b1;
            end
`endif
            if (r_cnt == CNT_MAX) begin
              r_err      <= 1'b1;
              r_idle_cnt <= '0;
              r_state    <= S_IDLE;
`ifdef UART_AUTOBAUD_CHECK_EN
            end else if (w_any_edge && w_ival_bad) begin
              r_err      <= 1'b1;
              r_idle_cnt <= '0;
              r_state    <= S_IDLE;
`endif
            end else if (w_fall) begin
              if (r_edge_cnt == 3'd3) begin
                if (w_cpb_bad) begin
                  r_err      <= 1'b1;
                  r_idle_cnt <= '0;
                  r_state    <= S_IDLE;
                end else begin
                  r_cpb_next <= w_cpb_next[CPB_WIDTH-1:0];
                  r_state    <= S_WAIT_STOP;
                end
              end else begin
                r_edge_cnt <= r_edge_cnt + 1'b1;
              end
            end
          end
          S_WAIT_STOP: begin
            if (w_rise) begin
              r_cpb    <= r_cpb_next;
              r_locked <= 1'b1;
              r_state  <= S_LOCK;
            end
          end
          S_LOCK: begin
            r_locked <= 1'b1;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign CPB    = r_cpb;
  assign LOCKED = r_locked;
  assign ERR    = r_err;

endmodule

// File: tb/tb_uart_autobaud.sv
// Self-checking bench for uart_autobaud: a timestamp-based model of the
// detector is compared against the DUT every cycle, and directed 0x55/0x41
// characters are sent with hand-computed expectations.
module tb_uart_autobaud;

  localparam int CPB_W     = 12;
  localparam int MIN_CPB   = 4;
  localparam int SYNC      = 2;
  localparam int CNT_LIMIT = (1 << (CPB_W + 3)) - 1;
`ifdef UART_AUTOBAUD_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic             CLK    = 1'b0;
  logic             RESETn = 1'b0;
  logic             RX_PIN = 1'b1;
  logic             RELOCK = 1'b0;
  logic [CPB_W-1:0] CPB;
  logic             LOCKED;
  logic             ERR;

  uart_autobaud #(.CPB_WIDTH(CPB_W), .MIN_CPB(MIN_CPB), .SYNC_STAGES(SYNC)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .RX_PIN (RX_PIN),
    .RELOCK (RELOCK),
    .CPB    (CPB),
    .LOCKED (LOCKED),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_HUNT, M_ARMED, M_TIMING, M_STOPWAIT, M_HELD} mphase_t;
  mphase_t m_phase = M_HUNT;
  logic h [0:SYNC] = '{default: 1'b1};  // pin samples, h[0] newest
  int  cyc = 0, high_run = 0, t0 = 0, t_last = 0, nfall = 0, ref_iv = 0, pend = 0;
  bit  have_ref = 1'b0;
  int  exp_cpb = 0;
  bit  exp_locked = 1'b0, exp_err = 1'b0;
  bit  m_rx, m_prev, m_fall, m_rise, m_rej;
  int  iv, dlt, period, cval;

  initial forever begin
    @(posedge CLK or negedge RESETn);
    if (!RESETn) begin
      m_phase = M_HUNT; high_run = 0; exp_cpb = 0; exp_locked = 0; exp_err = 0;
      for (int i = 0; i <= SYNC; i++) h[i] = 1'b1;
    end else begin
      cyc++;
      m_rx   = h[SYNC-1];
      m_prev = h[SYNC];
      m_fall = m_prev & ~m_rx;
      m_rise = ~m_prev & m_rx;
      m_rej  = 1'b0;
      exp_err = 1'b0;
      if (RELOCK && m_phase != M_HUNT) begin
        m_phase = M_HUNT; high_run = 0; exp_locked = 0;
      end else begin
        case (m_phase)
          M_HUNT: begin
            if (m_rx) begin
              high_run++;
              if (high_run == 16) begin m_phase = M_ARMED; high_run = 0; end
            end else high_run = 0;
          end
          M_ARMED: if (m_fall) begin
            t0 = cyc; t_last = cyc; nfall = 0; have_ref = 0; m_phase = M_TIMING;
          end
          M_TIMING: begin
            if (cyc - t0 > CNT_LIMIT) m_rej = 1'b1;
            else begin
              if (CHECK_EN && (m_fall || m_rise)) begin
                iv = cyc - t_last; t_last = cyc;
                if (!have_ref) begin ref_iv = iv; have_ref = 1'b1; end
                else begin
                  dlt = (iv > ref_iv) ? iv - ref_iv : ref_iv - iv;
                  if (dlt > ref_iv / 4) m_rej = 1'b1;
                end
              end
              if (!m_rej && m_fall) begin
                nfall++;
                if (nfall == 4) begin
                  period = cyc - t0;
                  cval = (period + 4) / 8;
                  if (cval < MIN_CPB || cval >= (1 << CPB_W)) m_rej = 1'b1;
                  else begin pend = cval; m_phase = M_STOPWAIT; end
                end
              end
            end
            if (m_rej) begin exp_err = 1'b1; m_phase = M_HUNT; high_run = 0; end
          end
          M_STOPWAIT: if (m_rise) begin
            exp_cpb = pend; exp_locked = 1'b1; m_phase = M_HELD;
          end
          default: ;
        endcase
      end
      for (int i = SYNC; i > 0; i--) h[i] = h[i-1];
      h[0] = RX_PIN;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial forever begin
    @(posedge CLK);
    #3;
    check("cycle CPB", 32'(CPB), 32'(exp_cpb));
    check("cycle LOCKED", 32'(LOCKED), 32'(exp_locked));
    check("cycle ERR", 32'(ERR), 32'(exp_err));
    if (ERR === 1'b1) err_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    RX_PIN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_sym(input logic [7:0] b, input int cpb, input int nsym);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < nsym; i++) begin
      RX_PIN = fr[i];
      repeat (cpb) @(negedge CLK);
    end
    RX_PIN = 1'b1;
  endtask

  task automatic wait_lock(input string name, input int budget);
    int n;
    n = 0;
    while (LOCKED !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({name, " locked"}, 32'(LOCKED), 32'd1);
  endtask

  task automatic pulse_relock();
    RELOCK = 1'b1;
    @(negedge CLK);
    RELOCK = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int  lat, e0, n;
  bit  fired;

  initial begin
    repeat (3) @(negedge CLK);
    check("reset CPB", 32'(CPB), 32'd0);
    check("reset LOCKED", 32'(LOCKED), 32'd0);
    check("reset ERR", 32'(ERR), 32'd0);
    RESETn = 1'b1;
    idle(20);

    // 0x55 at 100 cycles/bit; lock 9 bits + SYNC+1 after start bit.
    lat = 0;
    fork
      send_sym(8'h55, 100, 10);
      begin
        while (LOCKED !== 1'b1 && lat < 1100) begin
          @(negedge CLK);
          lat++;
        end
      end
    join
    check("lock latency 100", 32'(lat), 32'd903);
    check("CPB 100", 32'(CPB), 32'd100);
    check("LOCKED 100", 32'(LOCKED), 32'd1);
    check("no ERR 100", 32'(err_seen), 32'd0);

    // RELOCK drops LOCKED next cycle, CPB retained.
    pulse_relock();
    check("relock LOCKED", 32'(LOCKED), 32'd0);
    check("relock CPB kept", 32'(CPB), 32'd100);
    idle(40);
    send_sym(8'h55, 200, 10);
    wait_lock("cpb200", 20);
    check("CPB 200", 32'(CPB), 32'd200);

    // 103 cycles/bit: (824+4)>>3 = 103.
    pulse_relock();
    idle(40);
    send_sym(8'h55, 103, 10);
    wait_lock("cpb103", 20);
    check("CPB 103", 32'(CPB), 32'd103);

    // Minimum accepted rate.
    pulse_relock();
    idle(40);
    send_sym(8'h55, 4, 10);
    wait_lock("cpb4", 20);
    check("CPB 4", 32'(CPB), 32'd4);

    // Below minimum: one ERR pulse, no lock, CPB unchanged.
    pulse_relock();
    idle(40);
    e0 = err_seen;
    send_sym(8'h55, 3, 10);
    idle(5);
    check("cpb3 ERR pulses", 32'(err_seen - e0), 32'd1);
    check("cpb3 LOCKED", 32'(LOCKED), 32'd0);
    check("cpb3 CPB kept", 32'(CPB), 32'd4);
    idle(40);
    send_sym(8'h55, 50, 10);
    wait_lock("cpb50", 20);
    check("CPB 50", 32'(CPB), 32'd50);

    // RELOCK in the very cycle the stop-bit rise is detected wins.
    pulse_relock();
    idle(40);
    fired = 1'b0;
    fork
      send_sym(8'h55, 60, 10);
      begin
        for (int k = 0; k < 700 && !fired; k++) begin
          if (m_phase == M_STOPWAIT && h[SYNC-1] == 1'b1 && h[SYNC] == 1'b0) begin
            RELOCK = 1'b1;
            @(negedge CLK);
            RELOCK = 1'b0;
            fired = 1'b1;
          end else begin
            @(negedge CLK);
          end
        end
      end
    join
    check("race relock issued", 32'(fired), 32'd1);
    check("race LOCKED", 32'(LOCKED), 32'd0);
    check("race CPB kept", 32'(CPB), 32'd50);
    idle(40);
    send_sym(8'h55, 60, 10);
    wait_lock("cpb60", 20);
    check("CPB 60", 32'(CPB), 32'd60);

    // 0x41 is not a sync character: rejected (interval check or saturation).
    pulse_relock();
    idle(40);
    e0 = err_seen;
    send_sym(8'h41, 100, 10);
    n = 0;
    while (err_seen == e0 && n < 33000) begin
      @(negedge CLK);
      n++;
    end
    check("0x41 ERR pulses", 32'(err_seen - e0), 32'd1);
    check("0x41 no lock", 32'(LOCKED && (CPB == 12'd100)), 32'd0);
    check("0x41 LOCKED", 32'(LOCKED), 32'd0);
    check("0x41 CPB kept", 32'(CPB), 32'd60);

    // Asynchronous reset mid-measurement.
    idle(40);
    send_sym(8'h55, 100, 3);
    RESETn = 1'b0;
    #1;
    check("async reset CPB", 32'(CPB), 32'd0);
    check("async reset LOCKED", 32'(LOCKED), 32'd0);
    check("async reset ERR", 32'(ERR), 32'd0);
    RX_PIN = 1'b1;
    repeat (10) @(negedge CLK);
    RESETn = 1'b1;
    idle(20);
    send_sym(8'h55, 100, 10);
    wait_lock("post reset", 20);
    check("post reset CPB", 32'(CPB), 32'd100);

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Autobaud detector sitting directly upstream of the UART receiver and transmitter: it watches the raw RX pin for the 0x55 ('U') sync character and measures its bit period. It derives the shared clocks-per-bit value (CPB) that feeds both the receiver and the transmitter. It holds that value with LOCKED asserted until a relock is requested.

## Interface
- CPB_WIDTH, 12: width of the CPB output; the internal measurement counter is CPB_WIDTH+3 bits.
- MIN_CPB, 4: smallest accepted CPB; smaller results are rejected.
- SYNC_STAGES, 2: RX_PIN synchronizer depth (≥2).

Ports:
- CLK  in  1  system clock; the only clock.
- RESETn  in  1  reset, asynchronous, active-low.
- RX_PIN  in  1  raw asynchronous UART line, idle high.
- RELOCK  in  1  single-cycle pulse; abandon the current lock/measurement and restart detection.
- CPB  out  CPB_WIDTH  measured clocks per bit, valid while LOCKED=1.
- LOCKED  out  1  CPB valid; receiver/transmitter may run.
- ERR  out  1  one-cycle pulse on a rejected sync character.

## Operation
- RX_PIN passes through SYNC_STAGES flops giving rx_s; edges are detected on rx_s against its previous value. All edges below refer to these detected edges.
- 0x55 on the wire gives: start 0, then 1,0,1,0,1,0,1,0, then stop 1. Falling edges occur at bit times 0, 2, 4, 6 and 8.
- FSM states:
  - IDLE: waits for rx_s high for 16 consecutive cycles, then goes to WAIT_START.
  - WAIT_START: on a falling edge, clears cnt, edge_cnt and ival, then goes to MEASURE.
  - MEASURE: cnt increments every cycle. On every falling edge edge_cnt increments. On the 4th falling edge after the start edge, CPB_next = (cnt+4)>>3 is computed (rounded). cnt then holds the cycle difference between the start edge and the 5th falling edge, which spans 8 bit periods. The FSM then goes to WAIT_STOP.
  - WAIT_STOP: waits for the rising edge at the start of the stop bit, then loads CPB, asserts LOCKED and goes to LOCK.
  - LOCK: holds CPB and LOCKED. RX activity is ignored.
- Rejection (ERR pulse for one cycle, then go to IDLE, CPB unchanged):
  - cnt saturates at 2^(CPB_WIDTH+3)-1.
  - CPB_next < MIN_CPB.
  - CPB_next ≥ 2^CPB_WIDTH.
- RELOCK in any state: LOCKED drops the next cycle, the FSM goes to IDLE, CPB keeps its last value, and no ERR is raised. RELOCK while already in IDLE has no effect.
- No lock is possible without a full 0x55. A character with fewer falling edges stays in MEASURE until the counter saturates, then ERR.

## Timing
- Reset values: CPB=0, LOCKED=0, ERR=0; FSM in IDLE; all counters 0.
- Edge detection latency is SYNC_STAGES+1 cycles from an RX_PIN transition. This latency is equal for all edges, so the measurement is unaffected.
- LOCKED and CPB update together, in the cycle after the stop-bit rising edge is detected.
- The receiver therefore never sees the sync byte's start bit. The sync byte is consumed here.
- ERR is registered and is high for exactly one cycle. LOCKED is never high in the same cycle as ERR.
- A RELOCK arriving in the same cycle as lock completion wins: LOCKED stays 0.
- A reset asserted mid-measurement returns everything to reset values asynchronously.

## Configuration
- UART_AUTOBAUD_CHECK_EN defined: in MEASURE, ival counts cycles between consecutive edges of either polarity. The first interval is stored as ref.
  - Any later interval with |ival − ref| > ref>>2 rejects the character immediately (ERR, go to IDLE).
  - This rejects non-0x55 characters and glitches.
- Macro undefined: no per-interval check. Only the saturation and CPB range rejections apply; ival/ref logic is absent.

## Test plan
- 0x55 at 100 cycles/bit after reset and 20 idle cycles: LOCKED=1 about 900 cycles after the start edge, CPB=100, no ERR.
- 0x55 at 103 cycles/bit: cnt=824, giving CPB=(824+4)>>3=103. At 4 cycles/bit: CPB=4, locks.
- 0x55 at 3 cycles/bit: ERR single pulse, LOCKED=0, FSM back in IDLE. A following 0x55 at 50 cycles/bit locks with CPB=50.
- Lock at 100 cycles/bit, then RELOCK pulse: LOCKED=0 the next cycle, CPB stays 100. Then 0x55 at 200 cycles/bit: CPB=200, LOCKED=1.
- With UART_AUTOBAUD_CHECK_EN, send 0x41 at 100 cycles/bit: ERR pulse at the long-interval edge, no lock. Without the macro, the same stimulus must not produce LOCKED with CPB=100.
- RESETn asserted during MEASURE, released 10 cycles later: outputs 0 immediately. A following 0x55 at 100 cycles/bit locks with CPB=100.
